// File: rtl/fault_campaign_pkg.sv
// rtl/fault_campaign_pkg.sv - shared types and helpers for the fault campaign sequencer
package fault_campaign_pkg;

  typedef enum logic [2:0] {IDLE, GOLDEN, SWEEP, DRAIN, DONE} state_t;

  function automatic int gid_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [1:0] golden_mod3(input logic [31:0] a);
    return 2'(a % 32'd3);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    return (v >= max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/fault_campaign_ctrl_if.sv
// rtl/fault_campaign_ctrl_if.sv - stimulus/response bus between campaign sequencer and residue DUT
interface fault_campaign_ctrl_if #(
  parameter int NG  = 128,
  parameter int A_W = 5
);
  logic [A_W-1:0] A;
  logic [NG-1:0]  fault_en_bus;
  logic           fault_val;
  logic [1:0]     R_dut;

  modport master (output A, fault_en_bus, fault_val, input R_dut);
  modport slave  (input A, fault_en_bus, fault_val, output R_dut);
endinterface

// File: rtl/fault_campaign_checker.sv
// rtl/fault_campaign_checker.sv - delayed residue compare, saturating statistics, sticky gate map
// Optional first-fail capture is built when FIRST_FAIL_LOG_EN is defined.
module fault_campaign_checker
  import fault_campaign_pkg::*;
#(
  parameter int A_W     = 5,
  parameter int N_GATES = 8,
  parameter int CNT_W   = 16,
  parameter int GW      = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               flush,
  input  logic               app_valid,
  input  logic               app_faulty,
  input  logic [GW-1:0]      app_gid,
  input  logic               app_fval,
  input  logic [A_W-1:0]     app_a,
  input  logic [1:0]         r_dut,
  output logic [CNT_W-1:0]   golden_err_cnt,
  output logic [CNT_W-1:0]   mismatch_cnt,
  output logic [CNT_W-1:0]   invalid_cnt,
  output logic [N_GATES-1:0] gate_sensitive
`ifdef FIRST_FAIL_LOG_EN
  ,
  output logic               ff_valid,
  output logic [GW-1:0]      ff_gid,
  output logic               ff_val,
  output logic [A_W-1:0]     ff_a
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic           d_valid;
  logic           d_faulty;
  logic [GW-1:0]  d_gid;
  logic           d_fval;
  logic [A_W-1:0] d_a;
  logic [1:0]     d_r;
  logic           miss;

  assign miss = (d_r != golden_mod3(32'(d_a)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_valid        <= 1'b0;
      d_faulty       <= 1'b0;
      d_gid          <= '0;
      d_fval         <= 1'b0;
      d_a            <= '0;
      d_r            <= '0;
      golden_err_cnt <= '0;
      mismatch_cnt   <= '0;
      invalid_cnt    <= '0;
      gate_sensitive <= '0;
`ifdef FIRST_FAIL_LOG_EN
      ff_valid       <= 1'b0;
      ff_gid         <= '0;
      ff_val         <= 1'b0;
      ff_a           <= '0;
`endif
    end else begin
      // R_dut is captured with the vector it answers, so the compare sees a matched pair
      d_valid  <= app_valid && !flush;
      d_faulty <= app_faulty;
      d_gid    <= app_gid;
      d_fval   <= app_fval;
      d_a      <= app_a;
      d_r      <= r_dut;
      if (clear) begin
        golden_err_cnt <= '0;
        mismatch_cnt   <= '0;
        invalid_cnt    <= '0;
        gate_sensitive <= '0;
`ifdef FIRST_FAIL_LOG_EN
        ff_valid       <= 1'b0;
        ff_gid         <= '0;
        ff_val         <= 1'b0;
        ff_a           <= '0;
`endif
      end else if (d_valid && !flush) begin
        if (!d_faulty) begin
          if (miss) golden_err_cnt <= CNT_W'(sat_inc(32'(golden_err_cnt), 32'(CNT_MAX)));
        end else begin
          if (miss) begin
            mismatch_cnt          <= CNT_W'(sat_inc(32'(mismatch_cnt), 32'(CNT_MAX)));
            gate_sensitive[d_gid] <= 1'b1;
`ifdef FIRST_FAIL_LOG_EN
            if (!ff_valid) begin
              ff_valid <= 1'b1;
              ff_gid   <= d_gid;
              ff_val   <= d_fval;
              ff_a     <= d_a;
            end
`endif
          end
          if (d_r == 2'b11) invalid_cnt <= CNT_W'(sat_inc(32'(invalid_cnt), 32'(CNT_MAX)));
        end
      end
    end
  end

endmodule

// File: rtl/fault_campaign_ctrl.sv
// rtl/fault_campaign_ctrl.sv - exhaustive stuck-at campaign sequencer for a mod-3 residue DUT
// Define FIRST_FAIL_LOG_EN to add the first-fail capture outputs.
module fault_campaign_ctrl
  import fault_campaign_pkg::*;
#(
  parameter int NG       = 128,
  parameter int GID_BASE = 0,
  parameter int N_GATES  = 8,
  parameter int A_W      = 5,
  parameter int CNT_W    = 16,
  localparam int GW      = gid_w(N_GATES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  fault_campaign_ctrl_if.master bus,
  output logic [CNT_W-1:0]   golden_err_cnt,
  output logic [CNT_W-1:0]   mismatch_cnt,
  output logic [CNT_W-1:0]   invalid_cnt,
  output logic [N_GATES-1:0] gate_sensitive
`ifdef FIRST_FAIL_LOG_EN
  ,
  output logic               ff_valid,
  output logic [GW-1:0]      ff_gid,
  output logic               ff_val,
  output logic [A_W-1:0]     ff_a
`endif
);

  localparam logic [A_W-1:0] VEC_MAX  = '1;
  localparam logic [GW-1:0]  GID_LAST = GW'(N_GATES - 1);

  state_t         state_q, state_d;
  logic [A_W-1:0] vec_q, vec_d;
  logic [GW-1:0]  gid_q, gid_d;
  logic           fval_q, fval_d;
  logic [A_W-1:0] a_d;
  logic [NG-1:0]  en_d;
  logic           fv_d;
  logic           app_valid, app_valid_d;
  logic           app_faulty, app_faulty_d;
  logic [GW-1:0]  app_gid, app_gid_d;
  logic           busy_d, done_d, clear;

  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    gid_d        = gid_q;
    fval_d       = fval_q;
    a_d          = '0;
    en_d         = '0;
    fv_d         = 1'b0;
    app_valid_d  = 1'b0;
    app_faulty_d = 1'b0;
    app_gid_d    = gid_q;
    busy_d       = (state_q == GOLDEN) || (state_q == SWEEP) || (state_q == DRAIN);
    done_d       = (state_q == DONE);
    clear        = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = GOLDEN;
          vec_d   = '0;
          gid_d   = '0;
          fval_d  = 1'b0;
          clear   = 1'b1;
        end
      end
      GOLDEN: begin
        a_d         = vec_q;
        app_valid_d = 1'b1;
        vec_d       = vec_q + 1'b1;
        if (vec_q == VEC_MAX) state_d = SWEEP;
      end
      SWEEP: begin
        a_d          = vec_q;
        en_d         = {{(NG-1){1'b0}}, 1'b1} << (GID_BASE + int'(gid_q));
        fv_d         = fval_q;
        app_valid_d  = 1'b1;
        app_faulty_d = 1'b1;
        vec_d        = vec_q + 1'b1;
        // vector is the fastest loop, then stuck value, then gate
        if (vec_q == VEC_MAX) begin
          fval_d = ~fval_q;
          if (fval_q) begin
            gid_d = gid_q + 1'b1;
            if (gid_q == GID_LAST) state_d = DRAIN;
          end
        end
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d     = IDLE;
      a_d         = '0;
      en_d        = '0;
      fv_d        = 1'b0;
      app_valid_d = 1'b0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      vec_q            <= '0;
      gid_q            <= '0;
      fval_q           <= 1'b0;
      bus.A            <= '0;
      bus.fault_en_bus <= '0;
      bus.fault_val    <= 1'b0;
      app_valid        <= 1'b0;
      app_faulty       <= 1'b0;
      app_gid          <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
    end else begin
      state_q          <= state_d;
      vec_q            <= vec_d;
      gid_q            <= gid_d;
      fval_q           <= fval_d;
      bus.A            <= a_d;
      bus.fault_en_bus <= en_d;
      bus.fault_val    <= fv_d;
      app_valid        <= app_valid_d;
      app_faulty       <= app_faulty_d;
      app_gid          <= app_gid_d;
      busy             <= busy_d;
      done             <= done_d;
    end
  end

  fault_campaign_checker #(
    .A_W(A_W), .N_GATES(N_GATES), .CNT_W(CNT_W), .GW(GW)
  ) u_checker (
    .clk            (clk),
    .rst            (rst),
    .clear          (clear),
    .flush          (abort),
    .app_valid      (app_valid),
    .app_faulty     (app_faulty),
    .app_gid        (app_gid),
    .app_fval       (bus.fault_val),
    .app_a          (bus.A),
    .r_dut          (bus.R_dut),
    .golden_err_cnt (golden_err_cnt),
    .mismatch_cnt   (mismatch_cnt),
    .invalid_cnt    (invalid_cnt),
    .gate_sensitive (gate_sensitive)
`ifdef FIRST_FAIL_LOG_EN
    ,
    .ff_valid       (ff_valid),
    .ff_gid         (ff_gid),
    .ff_val         (ff_val),
    .ff_a           (ff_a)
`endif
  );

endmodule

// File: tb/tb_fault_campaign_ctrl.sv
// tb/tb_fault_campaign_ctrl.sv - self-checking bench for fault_campaign_ctrl with a behavioural residue DUT
module tb_fault_campaign_ctrl;

  localparam int NG   = 128;
  localparam int GB   = 5;
  localparam int NGT  = 8;
  localparam int AW   = 5;
  localparam int NV   = 32;
  localparam int CMAX = 65535;
  localparam int FULL = NV + NV * 2 * NGT;

  logic clk = 1'b0;
  logic rst, start, abort;
  always #5 clk = ~clk;

  logic        busy, done, busy_s, done_s;
  logic [15:0] gcnt, mcnt, icnt;
  logic [7:0]  gs, gs_s;
  logic [3:0]  gcnt_s, mcnt_s, icnt_s;
`ifdef FIRST_FAIL_LOG_EN
  logic        ffv, ffval, ffv_s, ffval_s;
  logic [2:0]  ffg, ffg_s;
  logic [4:0]  ffa, ffa_s;
`endif

  fault_campaign_ctrl_if #(.NG(NG), .A_W(AW)) bus ();
  fault_campaign_ctrl_if #(.NG(NG), .A_W(AW)) bus_s ();

  fault_campaign_ctrl #(.NG(NG), .GID_BASE(GB), .N_GATES(NGT), .A_W(AW), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done), .bus(bus),
    .golden_err_cnt(gcnt), .mismatch_cnt(mcnt), .invalid_cnt(icnt), .gate_sensitive(gs)
`ifdef FIRST_FAIL_LOG_EN
    , .ff_valid(ffv), .ff_gid(ffg), .ff_val(ffval), .ff_a(ffa)
`endif
  );

  fault_campaign_ctrl #(.NG(NG), .GID_BASE(0), .N_GATES(NGT), .A_W(AW), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy_s), .done(done_s), .bus(bus_s),
    .golden_err_cnt(gcnt_s), .mismatch_cnt(mcnt_s), .invalid_cnt(icnt_s), .gate_sensitive(gs_s)
`ifdef FIRST_FAIL_LOG_EN
    , .ff_valid(ffv_s), .ff_gid(ffg_s), .ff_val(ffval_s), .ff_a(ffa_s)
`endif
  );

  // Residue DUT model: per-gate stuck behaviour plus optional fault-free corruption
  bit             force_b0 [NGT];
  logic [1:0]     xm [NGT][2];
  logic [NV-1:0]  gbad;

  function automatic logic [1:0] model_resp(input int a, input int g, input bit v);
    logic [1:0] base;
    base = 2'(a % 3);
    if (g < 0) return base ^ {1'b0, gbad[a]};
    if (force_b0[g]) return {base[1], v};
    return base ^ xm[g][v];
  endfunction

  always_comb begin
    int g;
    g = -1;
    for (int i = 0; i < NG; i++) if (bus.fault_en_bus[i]) g = i - GB;
    if (bus.fault_en_bus != '0 && (g < 0 || g >= NGT)) bus.R_dut = 2'b11;
    else bus.R_dut = model_resp(int'(bus.A), g, bus.fault_val);
  end
  assign bus_s.R_dut = 2'b11;

  int viol = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.fault_en_bus == '0) begin
        if (bus.fault_val) viol++;
      end else if ($countones(bus.fault_en_bus) != 1 || bus.fault_en_bus[GB+NGT-1:GB] == '0) begin
        viol++;
      end
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int         e_g, e_m, e_i, e_ffg, e_ffval, e_ffa;
  logic [7:0] e_gs;
  bit         e_ffv;

  function automatic int sat(input int x, input int m);
    return (x > m) ? m : x;
  endfunction

  // Expected statistics after the first n applied samples of a campaign
  task automatic ref_model(input int n);
    int k;
    logic [1:0] r;
    k = 0; e_g = 0; e_m = 0; e_i = 0; e_gs = '0;
    e_ffv = 1'b0; e_ffg = 0; e_ffval = 0; e_ffa = 0;
    for (int a = 0; a < NV; a++) begin
      if (k < n && model_resp(a, -1, 1'b0) != 2'(a % 3)) e_g++;
      k++;
    end
    for (int g = 0; g < NGT; g++)
      for (int v = 0; v < 2; v++)
        for (int a = 0; a < NV; a++) begin
          if (k < n) begin
            r = model_resp(a, g, v[0]);
            if (r != 2'(a % 3)) begin
              e_m++;
              e_gs[g] = 1'b1;
              if (!e_ffv) begin
                e_ffv = 1'b1; e_ffg = g; e_ffval = v; e_ffa = a;
              end
            end
            if (r == 2'b11) e_i++;
          end
          k++;
        end
    e_g = sat(e_g, CMAX); e_m = sat(e_m, CMAX); e_i = sat(e_i, CMAX);
  endtask

  task automatic check_counts(input string ctx);
    check({ctx, ".golden_err_cnt"}, 64'(gcnt), 64'(e_g));
    check({ctx, ".mismatch_cnt"}, 64'(mcnt), 64'(e_m));
    check({ctx, ".invalid_cnt"}, 64'(icnt), 64'(e_i));
    check({ctx, ".gate_sensitive"}, 64'(gs), 64'(e_gs));
`ifdef FIRST_FAIL_LOG_EN
    check({ctx, ".ff_valid"}, 64'(ffv), 64'(e_ffv));
    check({ctx, ".ff_gid"}, 64'(ffg), 64'(e_ffg));
    check({ctx, ".ff_val"}, 64'(ffval), 64'(e_ffval));
    check({ctx, ".ff_a"}, 64'(ffa), 64'(e_ffa));
`endif
  endtask

  task automatic cfg_clear();
    for (int g = 0; g < NGT; g++) begin
      force_b0[g] = 1'b0; xm[g][0] = 2'b00; xm[g][1] = 2'b00;
    end
    gbad = '0;
  endtask

  task automatic cfg_random();
    for (int g = 0; g < NGT; g++) begin
      force_b0[g] = ($urandom_range(0, 3) == 0);
      for (int v = 0; v < 2; v++)
        xm[g][v] = ($urandom_range(0, 2) == 0) ? 2'b00 : 2'($urandom_range(0, 3));
    end
    gbad = $urandom & $urandom & $urandom;
  endtask

  task automatic run_campaign(input string ctx, input int restart_at);
    int cyc;
    bit seen;
    cyc = 0; seen = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!seen && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check({ctx, ".busy_after_start"}, 64'(busy), 64'd1);
      start = (cyc == restart_at);
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    check({ctx, ".latency"}, 64'(cyc), 64'd546);
    check({ctx, ".sat_done"}, 64'(done_s), 64'd1);
    check_counts(ctx);
    @(negedge clk);
    check({ctx, ".done_one_cycle"}, 64'(done), 64'd0);
    check({ctx, ".busy_after_done"}, 64'(busy), 64'd0);
    check({ctx, ".sat_busy_after_done"}, 64'(busy_s), 64'd0);
  endtask

  initial begin
    int done_cnt;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    cfg_clear();
    repeat (3) @(negedge clk);
    check("reset.busy", 64'(busy), 64'd0);
    check("reset.done", 64'(done), 64'd0);
    check("reset.A", 64'(bus.A), 64'd0);
    check("reset.fault_en_zero", 64'(bus.fault_en_bus == '0), 64'd1);
    check("reset.fault_val", 64'(bus.fault_val), 64'd0);
    check("reset.counters", {gcnt, mcnt, icnt, 8'h00, gs}, 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle.busy", 64'(busy), 64'd0);

    ref_model(FULL);
    run_campaign("clean", 0);
    check("sat.golden_err_cnt", 64'(gcnt_s), 64'(sat(NV, 15)));
    check("sat.mismatch_cnt", 64'(mcnt_s), 64'(sat(NV * 2 * NGT, 15)));
    check("sat.invalid_cnt", 64'(icnt_s), 64'(sat(NV * 2 * NGT, 15)));
    check("sat.gate_sensitive", 64'(gs_s), 64'hFF);
`ifdef FIRST_FAIL_LOG_EN
    check("sat.ff_valid", 64'(ffv_s), 64'd1);
    check("sat.ff_where", {ffg_s, ffval_s, ffa_s}, 64'd0);
`endif

    cfg_clear();
    force_b0[7] = 1'b1;
    ref_model(FULL);
    run_campaign("gate7", 0);
    check("gate7.mismatch_total", 64'(mcnt), 64'd32);
    check("gate7.invalid_total", 64'(icnt), 64'd10);
    check("gate7.sensitive_map", 64'(gs), 64'h80);

    for (int it = 0; it < 3; it++) begin
      cfg_random();
      ref_model(FULL);
      run_campaign($sformatf("rand%0d", it), (it == 1) ? int'($urandom_range(2, 540)) : 0);
    end

    cfg_random();
    ref_model(98);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort.A", 64'(bus.A), 64'd0);
    check("abort.fault_en_zero", 64'(bus.fault_en_bus == '0), 64'd1);
    check("abort.fault_val", 64'(bus.fault_val), 64'd0);
    check("abort.busy", 64'(busy), 64'd0);
    repeat (2) @(negedge clk);
    check_counts("abort_hold");

    abort = 1'b1; start = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_start.busy", 64'(busy), 64'd0);
    check_counts("abort_start_hold");
    done_cnt = 0;
    repeat (600) begin
      @(negedge clk);
      if (done || busy) done_cnt++;
    end
    check("abort.no_done_no_busy", 64'(done_cnt), 64'd0);

    ref_model(FULL);
    run_campaign("after_abort", 0);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (200) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst.busy", 64'(busy), 64'd0);
    check("midrst.A", 64'(bus.A), 64'd0);
    check("midrst.fault_en_zero", 64'(bus.fault_en_bus == '0), 64'd1);
    check("midrst.fault_val", 64'(bus.fault_val), 64'd0);
    check("midrst.counters", {gcnt, mcnt, icnt, 8'h00, gs}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("midrst.idle_busy", 64'(busy), 64'd0);

    cfg_random();
    ref_model(FULL);
    run_campaign("after_reset", 0);

    check("fault_bus_protocol", 64'(viol), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fault_campaign_ctrl.md
Name: fault_campaign_ctrl

Overview:
Sequencer for exhaustive fault-injection campaigns on a 5-bit mod-3 residue generator with a fault-enable bus.
- Sweeps every input vector, first fault-free, then once per target gate ID for each stuck value (0, 1).
- Compares the DUT residue against an internal golden A mod 3 and accumulates statistics.
- Sits between the testbench/top and the residue DUT; it drives A, fault_en_bus and fault_val.

Parameters:
NG, 128, width of fault_en_bus
GID_BASE, 0, first gate ID of the DUT instance
N_GATES, 8, number of consecutive gate IDs swept; GID_BASE+N_GATES <= NG is required
A_W, 5, DUT input width; vector sweep covers 0 .. 2^A_W-1
CNT_W, 16, width of statistic counters

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
start  in  1  begin campaign; sampled only in IDLE
abort  in  1  synchronous abort; back to IDLE next edge
busy  out  1  high from the cycle after start is accepted until DONE
done  out  1  one-cycle pulse at campaign end
A  out  A_W  DUT input vector, registered
fault_en_bus  out  NG  one-hot fault enable, registered
fault_val  out  1  stuck value, registered
R_dut  in  2  DUT residue (combinational response to A/fault outputs)
golden_err_cnt  out  CNT_W  mismatches during fault-free pass
mismatch_cnt  out  CNT_W  mismatches during faulty passes
invalid_cnt  out  CNT_W  faulty-pass samples with R_dut == 2'b11
gate_sensitive  out  N_GATES  sticky; bit g set if gate GID_BASE+g caused any mismatch

Behaviour:
- Reset (async) values: all outputs 0, FSM in IDLE, all counters 0.
- FSM states: IDLE -> GOLDEN -> SWEEP -> DRAIN -> DONE -> IDLE.
- IDLE: outputs A=0, fault_en_bus=0, fault_val=0; counters hold.
- start=1 in IDLE: clears all counters and gate_sensitive, then enters GOLDEN.
- GOLDEN: fault_en_bus=0; A steps 0..2^A_W-1, one vector per cycle.
- SWEEP: nested order, outer gid 0..N_GATES-1, middle fval 0 then 1, inner A 0..max.
  - fault_en_bus has only bit GID_BASE+gid set; fault_val=fval.
- Compare pipeline: applied vector, gid, fval and phase are delayed one cycle. R_dut is compared in the following cycle against golden = delayed A mod 3.
- DRAIN: compares the last vector with fault_en_bus already 0.
- DONE: done=1 for one cycle, busy=0, then IDLE.
- Latency with defaults: done asserts 546 cycles after the start edge (1 + 32 + 512 + 1).
- Counting rules:
  - A golden-phase mismatch increments golden_err_cnt.
  - A faulty-phase mismatch increments mismatch_cnt and sets gate_sensitive[gid].
  - R_dut == 3 in the faulty phase also increments invalid_cnt; this counts independently of mismatch.
  - All counters saturate at 2^CNT_W-1, with no wrap.
- start while busy: ignored.
- abort: returns to IDLE next edge and zeroes the fault/A outputs. The in-flight comparison is discarded, counters hold, and no done pulse is issued.
- abort and start in the same IDLE cycle: abort wins, so the campaign does not start.
- Reset mid-campaign clears everything immediately.

Optional Feature:
FIRST_FAIL_LOG_EN
- With the macro defined: extra outputs ff_valid (1), ff_gid (clog2 of N_GATES), ff_val (1) and ff_a (A_W).
  - They capture the first faulty-phase mismatch of a campaign and hold until the next start or reset.
  - All four outputs reset to 0.
- Without the macro: these ports do not exist and there is no capture logic.

Decomposition:
- Package fault_campaign_pkg holds:
  - the state enum (IDLE, GOLDEN, SWEEP, DRAIN, DONE);
  - the function golden_mod3(A) returning 2 bits;
  - a saturating-increment function.
- Sub-module fault_campaign_checker holds the delayed-compare stage, the three counters, gate_sensitive and the optional first-fail log.
- The top module keeps the FSM and vector/gid/fval counters.

Test Plan:
- Fault-free DUT model (R = A mod 3, fault inputs ignored), start -> done at cycle 546; all counters 0, gate_sensitive=0.
- DUT model forcing R[0]=fault_val when gate GID_BASE+7 is enabled -> mismatch_cnt=32 (11 for stuck-0, 21 for stuck-1), invalid_cnt=10, gate_sensitive=8'h80, golden_err_cnt=0.
- Same model with FIRST_FAIL_LOG_EN -> ff_valid=1, ff_gid=7, ff_val=0, ff_a=1.
- DUT always returning 2'b11 with CNT_W=4 -> every counter saturates at 15 with no wrap. gate_sensitive=8'hFF.
- abort at cycle 100 -> IDLE next edge, fault_en_bus=0, no done pulse. A new start clears counters and completes normally.
- rst asserted mid-SWEEP, start pulsed during busy -> reset asynchronously clears all outputs; the start during busy has no effect on sequencing.
